// File: rtl/rng_test_sequencer.sv
// Campaign controller that time-shares one serial bit source across N_TESTS
// randomness test cores, collecting per-core pass and timeout verdicts.
`timescale 1ns/1ps
module rng_test_sequencer #(
  parameter int N_TESTS = 2,
  parameter int SEQ_LEN = 128,
  parameter int TIMEOUT = 1024,
  localparam int CW = (N_TESTS > 1) ? $clog2(N_TESTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_TESTS-1:0] test_en,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic               eps_out,
  output logic [N_TESTS-1:0] eps_vld,
  input  logic [N_TESTS-1:0] core_valid,
  input  logic [N_TESTS-1:0] core_random,
  output logic               busy,
  output logic               done,
  output logic [N_TESTS-1:0] pass_mask,
  output logic [N_TESTS-1:0] timeout_mask,
  output logic [CW-1:0]      cur_test
);
  localparam int FW = $clog2(SEQ_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FEED_LAST = FW'(SEQ_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_FEED, S_WAIT, S_FIN} state_t;

  state_t             state_reg, state_next;
  logic [N_TESTS-1:0] pend_reg, pend_next;
  logic [N_TESTS-1:0] pass_reg, pass_next;
  logic [N_TESTS-1:0] tmo_reg, tmo_next;
  logic [N_TESTS-1:0] vld_reg, vld_next;
  logic [CW-1:0]      cur_reg, cur_next, low_idx;
  logic [FW-1:0]      feed_cnt_reg, feed_cnt_next;
  logic [TW-1:0]      tmo_cnt_reg, tmo_cnt_next;
  logic               eps_reg, eps_next;

  // Lowest pending test wins, so cores run in ascending index order.
  always_comb begin
    low_idx = '0;
    for (int i = N_TESTS - 1; i >= 0; i--) begin
      if (pend_reg[i]) low_idx = CW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      pend_reg     <= '0;
      pass_reg     <= '0;
      tmo_reg      <= '0;
      vld_reg      <= '0;
      cur_reg      <= '0;
      feed_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      eps_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_reg     <= pend_next;
      pass_reg     <= pass_next;
      tmo_reg      <= tmo_next;
      vld_reg      <= vld_next;
      cur_reg      <= cur_next;
      feed_cnt_reg <= feed_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      eps_reg      <= eps_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pend_next     = pend_reg;
    pass_next     = pass_reg;
    tmo_next      = tmo_reg;
    vld_next      = '0;
    cur_next      = cur_reg;
    feed_cnt_next = feed_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    eps_next      = eps_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          pend_next  = test_en;
          pass_next  = '0;
          tmo_next   = '0;
          state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (|pend_reg) begin
          cur_next      = low_idx;
          // x & (x-1) clears exactly the lowest set bit
          pend_next     = pend_reg & (pend_reg - N_TESTS'(1));
          feed_cnt_next = '0;
          state_next    = S_FEED;
        end else begin
          state_next = S_FIN;
        end
      end
      S_FEED: begin
        if (bit_valid) begin
          eps_next      = bit_in;
          vld_next      = N_TESTS'(1) << cur_reg;
          feed_cnt_next = feed_cnt_reg + FW'(1);
          if (feed_cnt_reg == FEED_LAST) begin
            tmo_cnt_next = '0;
            state_next   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        tmo_cnt_next = tmo_cnt_reg + TW'(1);
        // A verdict arriving on the expiry cycle takes priority over the timeout.
        if (core_valid[cur_reg]) begin
          pass_next[cur_reg] = core_random[cur_reg];
          state_next         = S_SELECT;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          tmo_next[cur_reg]  = 1'b1;
          pass_next[cur_reg] = 1'b0;
          state_next         = S_SELECT;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bit_ready    = (state_reg == S_FEED);
  assign busy         = (state_reg != S_IDLE);
  assign done         = (state_reg == S_FIN);
  assign eps_out      = eps_reg;
  assign eps_vld      = vld_reg;
  assign pass_mask    = pass_reg;
  assign timeout_mask = tmo_reg;
  assign cur_test     = cur_reg;
endmodule

// File: tb/tb_rng_test_sequencer.sv
// Directed bench for rng_test_sequencer: scripted campaigns with a small
// responding core model and hand-computed verdict masks.
`timescale 1ns/1ps
module tb_rng_test_sequencer;
  localparam int SEQ = 8;
  localparam int TMO = 16;

  logic       clk, rst, start, bit_in, bit_valid, bit_ready, eps_out, busy, done;
  logic [1:0] test_en, eps_vld, core_valid, core_random, pass_mask, timeout_mask;
  logic       cur_test;

  int n_cmp = 0;
  int n_err = 0;

  rng_test_sequencer #(.N_TESTS(2), .SEQ_LEN(SEQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .test_en(test_en),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .eps_out(eps_out), .eps_vld(eps_vld),
    .core_valid(core_valid), .core_random(core_random),
    .busy(busy), .done(done), .pass_mask(pass_mask),
    .timeout_mask(timeout_mask), .cur_test(cur_test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One campaign; cycle 0 is the start cycle, everything is observed on negedges.
  task automatic run(input string name, input logic [1:0] en, input bit toggle,
                     input logic [1:0] answers, input logic [1:0] rnd, input int delay,
                     input logic [1:0] noise, input bit midstart,
                     input logic [1:0] exp_pass, input logic [1:0] exp_tmo,
                     input int exp_done_cyc);
    int cyc, s0, s1, wcnt, wcore, ndone, done_cyc, cur_bad, n_acc, n_eps;
    bit finished, exp_cur;
    logic [31:0] acc_w, eps_w;
    logic [15:0] pat;
    pat = 16'hB4D3;
    s0 = 0; s1 = 0; wcnt = 0; wcore = -1; ndone = 0; done_cyc = -1;
    cur_bad = 0; n_acc = 0; n_eps = 0; acc_w = '0; eps_w = '0; finished = 0;
    @(negedge clk);
    start = 1'b1; test_en = en; bit_valid = 1'b0; bit_in = 1'b0;
    core_valid = noise; core_random = rnd | noise;
    cyc = 1;
    while (!finished && cyc < 600) begin
      @(negedge clk);
      start   = midstart && (cyc == 6);
      test_en = midstart ? 2'b11 : ~en;
      if (cyc == 1) chk({name, ":busy_on"}, busy, 1);
      if (wcore >= 0) wcnt++;
      if (eps_vld != 2'b00) begin eps_w = {eps_w[30:0], eps_out}; n_eps++; end
      if (eps_vld == 2'b01) begin
        s0++;
        if (s0 == SEQ) begin wcore = 0; wcnt = 0; end
      end else if (eps_vld == 2'b10) begin
        s1++;
        if (s1 == SEQ) begin wcore = 1; wcnt = 0; end
      end else if (eps_vld != 2'b00) cur_bad++;
      if (wcore >= 0 && !answers[wcore]) begin
        if (wcnt == TMO - 1) chk({name, ":tmo_early"}, timeout_mask[wcore], 0);
        if (wcnt == TMO)     chk({name, ":tmo_expiry"}, timeout_mask[wcore], 1);
      end
      if (wcore >= 0 && wcnt > TMO) wcore = -1;
      core_valid  = noise;
      core_random = rnd | noise;
      if (wcore >= 0 && answers[wcore] && wcnt == delay) core_valid[wcore] = 1'b1;
      if (bit_ready) begin
        exp_cur = (en[0] && s0 < SEQ) ? 1'b0 : 1'b1;
        if (cur_test != exp_cur) cur_bad++;
      end
      if (ndone > 0 && !done) begin
        chk({name, ":busy_off"}, busy, 0);
        finished = 1;
      end
      if (done) begin ndone++; done_cyc = cyc; end
      bit_valid = toggle ? cyc[0] : 1'b1;
      bit_in    = pat[cyc % 16];
      if (bit_valid && bit_ready) begin acc_w = {acc_w[30:0], bit_in}; n_acc++; end
      cyc++;
    end
    bit_valid = 1'b0; core_valid = 2'b00; test_en = 2'b00; start = 1'b0;
    chk({name, ":finished"}, finished, 1);
    chk({name, ":strobes0"}, s0, en[0] ? SEQ : 0);
    chk({name, ":strobes1"}, s1, en[1] ? SEQ : 0);
    chk({name, ":cur_bad"}, cur_bad, 0);
    chk({name, ":done_cnt"}, ndone, 1);
    if (exp_done_cyc >= 0) chk({name, ":done_cyc"}, done_cyc, exp_done_cyc);
    chk({name, ":pass"}, pass_mask, exp_pass);
    chk({name, ":timeout"}, timeout_mask, exp_tmo);
    chk({name, ":bit_count"}, n_eps, n_acc);
    chk({name, ":bit_seq"}, eps_w, acc_w);
    $display("run %s: en=%b strobes=%0d/%0d pass=%b tmo=%b done_cyc=%0d",
             name, en, s0, s1, pass_mask, timeout_mask, done_cyc);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; test_en = 2'b00; bit_in = 1'b0; bit_valid = 1'b0;
    core_valid = 2'b00; core_random = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset:busy", busy, 0);
    chk("reset:ready", bit_ready, 0);
    chk("reset:outs", {done, eps_out, eps_vld, pass_mask, timeout_mask, cur_test}, 0);
    rst = 1'b0;

    run("t1_both_pass", 2'b11, 0, 2'b11, 2'b11, 3,  2'b00, 0, 2'b11, 2'b00, -1);
    run("t2_core1_fail", 2'b10, 0, 2'b10, 2'b00, 2, 2'b01, 0, 2'b00, 2'b00, -1);
    run("t3_timeout",   2'b01, 0, 2'b00, 2'b00, 0,  2'b00, 0, 2'b00, 2'b01, -1);
    run("t4_toggle",    2'b01, 1, 2'b01, 2'b01, 0,  2'b00, 1, 2'b01, 2'b00, -1);

    // Asynchronous reset in the middle of feeding core 1.
    @(negedge clk);
    start = 1'b1; test_en = 2'b10; bit_valid = 1'b1; bit_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (eps_vld == 2'b10) seen = 1;
    end
    chk("t5:reach_feed", seen, 1);
    rst = 1'b1;
    #1;
    chk("t5:rst_busy", busy, 0);
    chk("t5:rst_ready", bit_ready, 0);
    chk("t5:rst_vld", eps_vld, 0);
    chk("t5:rst_eps", eps_out, 0);
    chk("t5:rst_cur", cur_test, 0);
    chk("t5:rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0;
    run("t5_after_rst", 2'b11, 0, 2'b11, 2'b01, 1, 2'b00, 0, 2'b01, 2'b00, -1);

    run("t6_expiry_rnd1", 2'b01, 0, 2'b01, 2'b01, TMO - 1, 2'b00, 0, 2'b01, 2'b00, -1);
    run("t6_expiry_rnd0", 2'b10, 0, 2'b10, 2'b00, TMO - 1, 2'b00, 0, 2'b00, 2'b00, -1);
    run("t6_empty",       2'b00, 0, 2'b00, 2'b00, 0,       2'b00, 0, 2'b00, 2'b00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
